// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor: FSM state encoding,
// default operand width and counter width.
package serial_sub_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int CNT_W         = $clog2(WIDTH_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when the counter is on the last bit position of an operand.
    function automatic logic is_last_bit(input logic [CNT_W-1:0] cnt, input int width);
        return cnt == CNT_W'(width - 1);
    endfunction

endpackage

// File: rtl/serial_sub8_full_sub.sv
// Single-bit full subtractor: d = a - b - bin, with borrow out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial subtractor d = x - y - bin, LSB first through one full_sub cell.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub8
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUB_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both
    // high; valid never depends on ready, and the payload is held while valid waits.

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] d_sr;
    logic [WIDTH-1:0] d_r;
    logic             br;
    logic             bout_r;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             cell_d;
    logic             cell_bout;

    assign last_bit = is_last_bit(cnt, WIDTH);

    full_sub u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands shift right so the cell always sees bit 0; the difference enters from
    // the MSB side, so after WIDTH bits it sits in natural order.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            d_r    <= '0;
            br     <= 1'b0;
            bout_r <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr <= x;
                        b_sr <= y;
                        br   <= bin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    d_sr <= {cell_d, d_sr[WIDTH-2:1]};
                    br   <= cell_bout;
                    cnt  <= cnt + 1'b1;
                    if (last_bit) begin
                        d_r    <= {cell_d, d_sr};
                        bout_r <= cell_bout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign d    = d_r;
    assign bout = bout_r;

`ifdef SERIAL_SUB_OVF_EN
    logic x_sign;
    logic y_sign;
    logic ovf_r;

    // Overflow only when the operand signs differ and the result sign leaves x's sign.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_sign <= 1'b0;
            y_sign <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                x_sign <= x[WIDTH-1];
                y_sign <= y[WIDTH-1];
            end
            if (state == RUN && last_bit) begin
                ovf_r <= (x_sign ^ y_sign) & (cell_d ^ x_sign);
            end
        end
    end

    assign ovf = ovf_r;
`endif

endmodule

// File: doc/serial_sub8.md
# serial_sub8

Bit-serial 8-bit subtractor with a borrow input and valid/ready handshakes on both sides. It computes d = x − y − bin one bit per clock, LSB first, through a single full-subtractor cell. It is the subtraction counterpart of the team's ripple-carry adder and trades eight cycles of latency for one bit-cell of logic. It sits between an operand producer and a result consumer that both use valid/ready flow control.

## Interface
- WIDTH, 8, operand and result width; 8 is the only verified value.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- x  input  WIDTH  minuend
- y  input  WIDTH  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- d  output  WIDTH  difference, x − y − bin mod 2^WIDTH
- bout  output  1  borrow out; 1 iff x < y + bin (unsigned)
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN

## Operation
- FSM states:
  - IDLE: in_ready=1. If in_valid, capture x, y, bin into shift registers, clear the bit counter, and go to RUN.
  - RUN: each cycle, one full-subtractor bit: diff = a^b^br; borrow = (~a&b) | (~(a^b)&br). Shift the diff into d from the MSB side and shift the operands right. The counter increments. After the WIDTH-th bit, go to DONE.
  - DONE: out_valid=1. When out_ready, go to IDLE.
- in_ready is high only in IDLE and is forced low while rst=1. in_valid is ignored in RUN and DONE.
- d, bout and ovf stay stable throughout DONE. They hold their last value outside DONE and are meaningful only while out_valid=1.
- bout is the borrow out of the final (MSB) bit.
- There is no pipelining: throughput is one operation per WIDTH+2 cycles at best.

## Timing
- Reset values: state IDLE, out_valid=0, d=0, bout=0, ovf=0, counter=0, borrow flop=0.
- Accept edge at cycle k, defined as the edge where in_valid & in_ready.
- RUN processes bits 0..7 on edges k+1..k+8. out_valid rises after edge k+8, so latency from accept to out_valid is 8 cycles.
- Handshake completes on an edge where out_valid & out_ready. out_valid=0 and in_ready=1 follow in the next cycle.
- If out_ready is already high when DONE is entered, DONE lasts exactly one cycle.
- Counter wrap: 3 bits, terminal count 7 → DONE. The counter does not advance outside RUN.
- Reset mid-operation, in any state: on the next edge the block is in IDLE, out_valid=0, and the partial result is discarded. No result is ever emitted for the aborted operation.
- in_valid and rst high together: reset wins and no capture occurs.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - port ovf exists.
  - ovf = (x[7] ≠ y[7]) & (d[7] ≠ x[7]), with x and y as captured at accept.
  - Registered with d and valid in DONE.
- SERIAL_SUB_OVF_EN undefined: no ovf port, no sign-capture flops.
- All other behaviour is identical in both builds.

## Structure
- Package serial_sub_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - localparam CNT_W = $clog2(WIDTH);
  - the default width constant.
- Sub-module full_sub (inputs a, b, bin; outputs d, bout) is the single combinational bit cell, instantiated once.
- The top level holds the FSM, the operand and result shift registers, the borrow flop and the counter.

## Test plan
- x=0x05, y=0x03, bin=0 → d=0x02, bout=0; out_valid exactly 8 cycles after accept.
- x=0x00, y=0x01, bin=0 → d=0xFF, bout=1 (wrap).
- x=0x80, y=0x01, bin=0 → d=0x7F, bout=0, ovf=1 (macro build); same vector in the non-macro build has no ovf port.
- x=0xFF, y=0xFF, bin=1 → d=0xFF, bout=1. x=0xFF, y=0x00, bin=1 → d=0xFE, bout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands → d/bout held, in_ready=0, no capture; release → one handshake, then in_ready=1 and the new operands are accepted.
- rst pulsed for one cycle after bit 4 of x=0x10, y=0x01 → next cycle IDLE, out_valid=0, no result emitted; then x=0x10, y=0x01 → d=0x0F, bout=0.
